// File: rtl/adc_frame_aligner.sv
// adc_frame_aligner: bitslip-driven frame alignment and sample unpacking
// for multi-lane serial ADCs, running in the divided ADC clock domain.
//
// Ports:
//   clk, reset_n   divided ADC clock, async active-low reset
//   din            deserialized word; lane k bit t at din[t*NL+k]
//   realign        one-cycle pulse forcing a fresh search
//   fmt_offset     1 = offset-binary input (MSB inverted)
//   bitslip        one-cycle pulse to the SERDES BITSLIP input
//   data           sign-extended samples, channel c at [c*OUT_W +: OUT_W]
//   data_valid     sample came from a good frame while locked
//   locked         aligner is in LOCKED
//   align_err      sticky: a full sweep of MAX_SLIPS failed to lock
//   slip_count     saturating total of bitslip pulses
//   relock_count   saturating count of LOCKED->SEARCH drops
//   frame_word     registered frame lane word
module adc_frame_aligner #(
  parameter int unsigned    NUM_CH     = 2,
  parameter int unsigned    LANES      = 2,
  parameter int unsigned    SER        = 7,
  parameter int unsigned    OUT_W      = 16,
  parameter logic [SER-1:0] FRAME_PAT  = {SER{1'b0}},
  parameter int unsigned    LOCK_CNT   = 4,
  parameter int unsigned    LOSS_CNT   = 4,
  parameter int unsigned    SETTLE_CYC = 4,
  parameter int unsigned    MAX_SLIPS  = 7
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [(NUM_CH*LANES+1)*SER-1:0]   din,
  input  logic                              realign,
  input  logic                              fmt_offset,
  output logic                              bitslip,
  output logic [NUM_CH*OUT_W-1:0]           data,
  output logic                              data_valid,
  output logic                              locked,
  output logic                              align_err,
  output logic [7:0]                        slip_count,
  output logic [7:0]                        relock_count,
  output logic [SER-1:0]                    frame_word
);

  localparam int unsigned NL = NUM_CH*LANES + 1;
  localparam int unsigned FL = NUM_CH*LANES;
  localparam int unsigned RW = LANES*SER;
  localparam int unsigned CW = 16;

  localparam logic [CW-1:0] LOCK_C   = CW'(LOCK_CNT);
  localparam logic [CW-1:0] LOSS_C   = CW'(LOSS_CNT);
  localparam logic [CW-1:0] SETTLE_L = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] MAXS_C   = CW'(MAX_SLIPS);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_SLIP,
    S_SETTLE,
    S_LOCKED
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] good_q, good_d;
  logic [CW-1:0] bad_q, bad_d;
  logic [CW-1:0] slipc_q, slipc_d;
  logic [CW-1:0] settle_q, settle_d;
  logic [CW-1:0] good_inc, bad_inc;
  logic [CW-1:0] slip_inc, settle_inc;

  logic          err_q, err_d;
  logic [7:0]    scnt_q, scnt_d;
  logic [7:0]    rcnt_q, rcnt_d;

  logic          bitslip_q;
  logic          valid_q;
  logic          locked_q;
  logic [NUM_CH*OUT_W-1:0] data_q, data_d;
  logic [SER-1:0] fw_q, fw;

  logic          good;

  // Frame lane word, earliest bit in the MSB.
  for (genvar t = 0; t < SER; t++) begin : g_fw
    assign fw[SER-1-t] = din[t*NL + FL];
  end

  assign good = (fw == FRAME_PAT) || (fw == ~FRAME_PAT);

  // Channel unpack: highest lane supplies the top SER bits.
  logic [NUM_CH-1:0][RW-1:0] raw;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_raw
    for (genvar l = 0; l < LANES; l++) begin : g_ln
      for (genvar t = 0; t < SER; t++) begin : g_bit
        assign raw[c][l*SER + SER-1-t] =
          din[t*NL + c*LANES + l];
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [RW-1:0] smp;
    assign smp = {raw[c][RW-1] ^ fmt_offset,
                  raw[c][RW-2:0]};
    assign data_d[c*OUT_W +: OUT_W] =
      OUT_W'($signed(smp));
  end

  assign good_inc   = good_q + CW'(1);
  assign bad_inc    = bad_q + CW'(1);
  assign slip_inc   = slipc_q + CW'(1);
  assign settle_inc = settle_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    bad_d    = bad_q;
    slipc_d  = slipc_q;
    settle_d = settle_q;
    err_d    = err_q;
    scnt_d   = scnt_q;
    rcnt_d   = rcnt_q;

    if (realign) begin
      state_d  = S_SEARCH;
      good_d   = '0;
      bad_d    = '0;
      slipc_d  = '0;
      settle_d = '0;
      err_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_SEARCH: begin
          if (good) begin
            if (good_inc == LOCK_C) begin
              state_d = S_LOCKED;
              good_d  = '0;
              bad_d   = '0;
              slipc_d = '0;
            end else begin
              good_d = good_inc;
            end
          end else begin
            good_d  = '0;
            state_d = S_SLIP;
          end
        end
        S_SLIP: begin
          if (scnt_q != 8'hFF) begin
            scnt_d = scnt_q + 8'd1;
          end
          // A full sweep without lock flags the error and
          // starts a new sweep.
          if (slip_inc == MAXS_C) begin
            err_d   = 1'b1;
            slipc_d = '0;
          end else begin
            slipc_d = slip_inc;
          end
          settle_d = '0;
          state_d  = S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_q == SETTLE_L) begin
            settle_d = '0;
            good_d   = '0;
            state_d  = S_SEARCH;
          end else begin
            settle_d = settle_inc;
          end
        end
        S_LOCKED: begin
          if (good) begin
            bad_d = '0;
          end else if (bad_inc == LOSS_C) begin
            bad_d   = '0;
            good_d  = '0;
            state_d = S_SEARCH;
            if (rcnt_q != 8'hFF) begin
              rcnt_d = rcnt_q + 8'd1;
            end
          end else begin
            bad_d = bad_inc;
          end
        end
        default: begin
          state_d = S_SEARCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_SEARCH;
      good_q    <= '0;
      bad_q     <= '0;
      slipc_q   <= '0;
      settle_q  <= '0;
      err_q     <= 1'b0;
      scnt_q    <= '0;
      rcnt_q    <= '0;
      bitslip_q <= 1'b0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      data_q    <= '0;
      fw_q      <= '0;
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      slipc_q   <= slipc_d;
      settle_q  <= settle_d;
      err_q     <= err_d;
      scnt_q    <= scnt_d;
      rcnt_q    <= rcnt_d;
      // Pulse coincides with the cycle spent in SLIP.
      bitslip_q <= (state_d == S_SLIP);
      valid_q   <= (state_q == S_LOCKED) && good;
      locked_q  <= (state_q == S_LOCKED);
      data_q    <= data_d;
      fw_q      <= fw;
    end
  end

  assign bitslip      = bitslip_q;
  assign data         = data_q;
  assign data_valid   = valid_q;
  assign locked       = locked_q;
  assign align_err    = err_q;
  assign slip_count   = scnt_q;
  assign relock_count = rcnt_q;
  assign frame_word   = fw_q;

endmodule

// File: tb/tb_adc_frame_aligner.sv
// tb_adc_frame_aligner: directed bench for adc_frame_aligner with a
// small SERDES model that rotates the frame lane on each bitslip.
module tb_adc_frame_aligner;

  localparam logic [6:0] PAT = 7'b0000111;
  localparam logic [6:0] BAD = 7'b0101010;

  logic        clk;
  logic        reset_n;
  logic [34:0] din;
  logic        realign;
  logic        fmt_offset;
  logic        bitslip;
  logic [31:0] data;
  logic        data_valid;
  logic        locked;
  logic        align_err;
  logic [7:0]  slip_count;
  logic [7:0]  relock_count;
  logic [6:0]  frame_word;

  int errors = 0;
  int checks = 0;

  adc_frame_aligner #(
    .FRAME_PAT (PAT)
  ) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .din          (din),
    .realign      (realign),
    .fmt_offset   (fmt_offset),
    .bitslip      (bitslip),
    .data         (data),
    .data_valid   (data_valid),
    .locked       (locked),
    .align_err    (align_err),
    .slip_count   (slip_count),
    .relock_count (relock_count),
    .frame_word   (frame_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [34:0] pack(
    input logic [6:0]  fw,
    input logic [13:0] a,
    input logic [13:0] b
  );
    logic [34:0] d;
    logic [6:0]  ln [5];
    ln[0] = a[6:0];
    ln[1] = a[13:7];
    ln[2] = b[6:0];
    ln[3] = b[13:7];
    ln[4] = fw;
    d = '0;
    for (int t = 0; t < 7; t++)
      for (int k = 0; k < 5; k++)
        d[t*5+k] = ln[k][6-t];
    return d;
  endfunction

  function automatic logic [6:0] rotl(
    input logic [6:0] x,
    input int         n
  );
    logic [6:0] r;
    r = x;
    for (int i = 0; i < n % 7; i++)
      r = {r[5:0], r[6]};
    return r;
  endfunction

  task automatic tick(input logic [34:0] d);
    din = d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    din        = '0;
    realign    = 1'b0;
    fmt_offset = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bitslip, data_valid, locked, align_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000",
               {bitslip, data_valid, locked, align_err});
    end
    checks++;
    if (data !== 32'h0 || frame_word !== 7'h0) begin
      errors++;
      $display("FAIL reset_data data=%h fw=%b exp=0",
               data, frame_word);
    end
    checks++;
    if (slip_count !== 8'd0 || relock_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt slip=%0d relock=%0d exp=0",
               slip_count, relock_count);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_lock();
    int saw_slip;
    saw_slip = 0;
    tick(pack(PAT, 14'h2ABC, 14'h1F00));
    checks++;
    if (data !== 32'h1F00EABC || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL lock_first data=%h dv=%b exp=1f00eabc/0",
               data, data_valid);
    end
    for (int i = 1; i < 4; i++) begin
      tick(pack(PAT, 14'h2ABC, 14'h1F00));
      if (bitslip) saw_slip++;
    end
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_early locked=%b exp=0", locked);
    end
    tick(pack(PAT, 14'h2ABC, 14'h1F00));
    if (bitslip) saw_slip++;
    checks++;
    if (locked !== 1'b1 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL lock_c5 locked=%b dv=%b exp=1/1",
               locked, data_valid);
    end
    checks++;
    if (data !== 32'h1F00EABC || frame_word !== PAT) begin
      errors++;
      $display("FAIL lock_data data=%h fw=%b exp=1f00eabc/%b",
               data, frame_word, PAT);
    end
    checks++;
    if (saw_slip != 0) begin
      errors++;
      $display("FAIL lock_noslip pulses=%0d exp=0", saw_slip);
    end
  endtask

  task automatic test_loss();
    int bad_dv;
    bad_dv = 0;
    for (int i = 0; i < 3; i++) begin
      tick(pack(BAD, 14'h0123, 14'h0456));
      if (data_valid !== 1'b0 || locked !== 1'b1) bad_dv++;
    end
    checks++;
    if (bad_dv != 0) begin
      errors++;
      $display("FAIL loss_3bad wrong=%0d exp=0 (dv=0,locked=1)",
               bad_dv);
    end
    tick(pack(PAT, 14'h0123, 14'h0456));
    checks++;
    if (data_valid !== 1'b1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL loss_good dv=%b locked=%b exp=1/1",
               data_valid, locked);
    end
    for (int i = 0; i < 4; i++)
      tick(pack(BAD, 14'h0, 14'h0));
    checks++;
    if (locked !== 1'b1 || relock_count !== 8'd1) begin
      errors++;
      $display("FAIL loss_4bad locked=%b relock=%0d exp=1/1",
               locked, relock_count);
    end
    tick(pack(PAT, 14'h0, 14'h0));
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL loss_drop locked=%b exp=0", locked);
    end
    for (int i = 0; i < 4; i++)
      tick(pack(PAT, 14'h0, 14'h0));
    checks++;
    if (locked !== 1'b1 || relock_count !== 8'd1) begin
      errors++;
      $display("FAIL loss_relock locked=%b relock=%0d exp=1/1",
               locked, relock_count);
    end
  endtask

  task automatic test_fmt();
    fmt_offset = 1'b1;
    tick(pack(~PAT, 14'h0000, 14'h3FFF));
    checks++;
    if (data !== 32'h1FFFE000 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL fmt_off_a data=%h dv=%b exp=1fffe000/1",
               data, data_valid);
    end
    tick(pack(PAT, 14'h3FFF, 14'h0000));
    checks++;
    if (data !== 32'hE0001FFF) begin
      errors++;
      $display("FAIL fmt_off_b data=%h exp=e0001fff", data);
    end
    fmt_offset = 1'b0;
    tick(pack(PAT, 14'h0000, 14'h3FFF));
    checks++;
    if (data !== 32'hFFFF0000) begin
      errors++;
      $display("FAIL fmt_twos data=%h exp=ffff0000", data);
    end
  endtask

  task automatic test_slip_align();
    int np, last, ph, bad_gap;
    np = 0; last = 0; ph = 0; bad_gap = 0;
    do_reset();
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(pack(rotl(7'b1110000, ph), 14'h0, 14'h0));
      if (bitslip) begin
        if (np > 0 && i - last != 6) bad_gap++;
        last = i;
        np++;
        ph++;
      end
    end
    checks++;
    if (np != 3 || bad_gap != 0) begin
      errors++;
      $display("FAIL slip_pulses n=%0d badgap=%0d exp=3/0",
               np, bad_gap);
    end
    checks++;
    if (slip_count !== 8'd3 || align_err !== 1'b0) begin
      errors++;
      $display("FAIL slip_cnt cnt=%0d err=%b exp=3/0",
               slip_count, align_err);
    end
    checks++;
    if (locked !== 1'b1 || frame_word !== PAT) begin
      errors++;
      $display("FAIL slip_lock locked=%b fw=%b exp=1/%b",
               locked, frame_word, PAT);
    end
  endtask

  task automatic test_never_lock();
    int np;
    bit seen;
    np = 0; seen = 1'b0;
    do_reset();
    reset_n = 1'b1;
    for (int i = 0; i < 1600; i++) begin
      tick(pack(BAD, 14'h0, 14'h0));
      if (bitslip) begin
        np++;
        if (np == 7) begin
          checks++;
          if (align_err !== 1'b0) begin
            errors++;
            $display("FAIL nl_err_early err=%b exp=0", align_err);
          end
        end
      end else if (np == 7 && !seen) begin
        seen = 1'b1;
        checks++;
        if (align_err !== 1'b1 || slip_count !== 8'd7) begin
          errors++;
          $display("FAIL nl_err7 err=%b cnt=%0d exp=1/7",
                   align_err, slip_count);
        end
      end
    end
    checks++;
    if (slip_count !== 8'd255 || np < 256) begin
      errors++;
      $display("FAIL nl_sat cnt=%0d pulses=%0d exp=255/>=256",
               slip_count, np);
    end
    for (int i = 0; i < 40; i++) begin
      if (locked) break;
      tick(pack(PAT, 14'h0, 14'h0));
    end
    checks++;
    if (locked !== 1'b1 || align_err !== 1'b1) begin
      errors++;
      $display("FAIL nl_lock locked=%b err=%b exp=1/1",
               locked, align_err);
    end
  endtask

  task automatic test_realign();
    realign = 1'b1;
    tick(pack(PAT, 14'h0, 14'h0));
    realign = 1'b0;
    checks++;
    if (locked !== 1'b1 || align_err !== 1'b0) begin
      errors++;
      $display("FAIL ra_n1 locked=%b err=%b exp=1/0",
               locked, align_err);
    end
    tick(pack(PAT, 14'h0, 14'h0));
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL ra_n2 locked=%b exp=0", locked);
    end
    for (int i = 0; i < 3; i++)
      tick(pack(PAT, 14'h0, 14'h0));
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL ra_early locked=%b exp=0", locked);
    end
    tick(pack(PAT, 14'h0, 14'h0));
    checks++;
    if (locked !== 1'b1 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL ra_relock locked=%b dv=%b exp=1/1",
               locked, data_valid);
    end
    checks++;
    if (slip_count !== 8'd255 || align_err !== 1'b0) begin
      errors++;
      $display("FAIL ra_cnt cnt=%0d err=%b exp=255/0",
               slip_count, align_err);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    din        = '0;
    realign    = 1'b0;
    fmt_offset = 1'b0;
    test_reset();
    test_lock();
    test_loss();
    test_fmt();
    test_slip_align();
    test_never_lock();
    test_realign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_frame_aligner.md
# adc_frame_aligner

Parametrised frame aligner and sample unpacker for multi-lane serial ADCs. It sits between the SERDES deserializer wrapper and the sample FIFO, and runs in the divided ADC clock domain. It drives the SERDES bitslip input until the frame lane matches the expected pattern, and declares lock with hysteresis. Once locked, it unpacks each channel's lanes into sign-extended two's-complement samples with a qualifying valid strobe.

## Interface
- NUM_CH, 2, number of ADC channels
- LANES, 2, serial lanes per channel
- SER, 7, deserialization factor (bits per lane per clk)
- OUT_W, 16, output width per channel; must be ≥ LANES*SER
- FRAME_PAT, {SER{1'b0}}, expected frame word; its bitwise inverse is also accepted
- LOCK_CNT, 4, consecutive good frames needed to lock (≥1)
- LOSS_CNT, 4, consecutive bad frames that drop lock (≥1)
- SETTLE_CYC, 4, wait cycles after each bitslip pulse (≥1)
- MAX_SLIPS, 7, slips per search sweep before align_err is raised

Ports (NL = NUM_CH*LANES+1):
- clk  in  1  divided ADC clock from the deserializer; the only clock
- reset_n  in  1  asynchronous, active-low reset
- din  in  NL*SER  deserialized word; bit t of lane k is at din[t*NL+k], t=0 is earliest/most significant
- realign  in  1  one-cycle pulse; forces a new search
- fmt_offset  in  1  1 = ADC output is offset binary (invert MSB); 0 = two's complement
- bitslip  out  1  one-cycle pulse to the SERDES BITSLIP input
- data  out  NUM_CH*OUT_W  channel c at data[c*OUT_W +: OUT_W]
- data_valid  out  1  data holds a sample from a good frame while locked
- locked  out  1  aligner is in LOCKED
- align_err  out  1  sticky: a full sweep of MAX_SLIPS failed to lock
- slip_count  out  8  total bitslip pulses issued, saturating at 255
- relock_count  out  8  number of LOCKED→SEARCH transitions, saturating at 255
- frame_word  out  SER  registered frame lane word, for debug

## Operation
- Lane mapping: channel c, lane l → k = c*LANES+l; frame lane k = NUM_CH*LANES.
- Raw sample = concatenation of lanes from l=LANES-1 down to 0, each lane contributing bits t=0..SER-1, MSB first.
- frame_word = {din[0*NL+F], …, din[(SER-1)*NL+F]}, F = frame lane.
- A frame is good iff frame_word == FRAME_PAT or frame_word == ~FRAME_PAT.
- Sample formatting:
  - If fmt_offset=1, the raw MSB is inverted.
  - The result is sign-extended from bit LANES*SER-1 to OUT_W.
- States:
  - SEARCH: on a good frame, increment good_cnt; when good_cnt reaches LOCK_CNT, go to LOCKED. On a bad frame, clear good_cnt and go to SLIP.
  - SLIP: assert bitslip for exactly one cycle, increment slip_cnt and slip_count, then go to SETTLE. When slip_cnt reaches MAX_SLIPS, set align_err, clear slip_cnt, and keep searching (retry indefinitely).
  - SETTLE: wait SETTLE_CYC cycles with frames ignored, then go to SEARCH with good_cnt=0.
  - LOCKED:
    - A good frame clears bad_cnt.
    - A bad frame increments bad_cnt.
    - When bad_cnt reaches LOSS_CNT, go to SEARCH and increment relock_count.
    - slip_cnt clears on entry to LOCKED.
- realign=1 in any state → next state SEARCH; good_cnt, bad_cnt and slip_cnt clear; align_err clears. realign takes priority over all other transitions.
- align_err stays set through LOCKED and clears only on reset or realign.
- slip_count and relock_count saturate and do not wrap.

## Timing
- Reset (asynchronous, reset_n=0):
  - State = SEARCH; all counters = 0.
  - bitslip, data_valid, locked, align_err = 0.
  - data = 0; frame_word = 0; slip_count = relock_count = 0.
- All outputs are registered. data, data_valid and frame_word have 1-cycle latency from din.
- data_valid in cycle n+1 = (state==LOCKED at n) AND (frame good at n).
- locked in cycle n+1 = (state==LOCKED at n).
- data updates every cycle regardless of valid.
- Lock from reset with a correct phase: good frames at cycles 0..LOCK_CNT-1 put the state in LOCKED at cycle LOCK_CNT. locked and the first data_valid appear at cycle LOCK_CNT+1.
- Spacing between bitslip pulses is SETTLE_CYC+2 cycles minimum: SLIP, then SETTLE×SETTLE_CYC, then SEARCH evaluation.
- A bad frame while LOCKED deasserts data_valid for that sample only; locked drops one cycle after the LOSS_CNT-th consecutive bad frame.
- reset_n deassertion mid-search restarts cleanly; no bitslip is issued in the first cycle after reset.

## Test plan
- Defaults, frame lane constant 0, lane data with cha=14'h2ABC, chb=14'h1F00 → no bitslip; locked at cycle 5; data = {16'h1F00, 16'hEABC}, data_valid=1.
- Frame phase rotated by 3 bits (pattern 1110000 per cycle) → exactly 3 bitslip pulses, each 6 cycles apart; lock follows; slip_count=3; align_err=0.
- Frame lane never matches → align_err rises after 7 slips; bitslip keeps pulsing; slip_count saturates at 255.
- Locked, then inject 3 bad frames followed by a good one → locked stays 1; data_valid low on the 3 bad samples only. Then inject 4 bad frames → locked=0; relock_count=1.
- fmt_offset=1 with raw sample 14'h0000 → data channel = 16'hE000; raw 14'h3FFF → 16'h1FFF.
- realign pulse while LOCKED → locked=0 two cycles later; good_cnt restarts; lock reacquired after LOCK_CNT good frames; align_err cleared.
